// File: rtl/pipe_pkg.sv
// Shared pipeline types: decoded control bundle and EX forwarding selects.
package pipe_pkg;

  localparam int unsigned ALUOP_W = 4;

  // Decoded control carried from ID into EX.
  typedef struct packed {
    logic [ALUOP_W-1:0] aluop;
    logic               alusrc;
    logic               memread;
    logic               memwrite;
    logic               regwrite;
    logic               memtoreg;
    logic               branch;
    logic               use_rs1;
    logic               use_rs2;
  } ctrl_t;

  // Source of an EX operand.
  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding select for one EX operand.
//   iValid              EX slot valid
//   iUse                EX instruction reads this operand
//   iRs                 EX source register index
//   iExmem_we/iExmem_rd EX/MEM producer
//   iMemwb_we/iMemwb_rd MEM/WB producer
//   oSel                combinational forwarding select
module fwd_unit
  import pipe_pkg::*;
#(
  parameter int unsigned REGW = 5
) (
  input  logic            iValid,
  input  logic            iUse,
  input  logic [REGW-1:0] iRs,
  input  logic            iExmem_we,
  input  logic [REGW-1:0] iExmem_rd,
  input  logic            iMemwb_we,
  input  logic [REGW-1:0] iMemwb_rd,
  output fwd_sel_t        oSel
);

  logic exmem_hit_c;
  logic memwb_hit_c;

  // x0 is hardwired zero, so a producer targeting it never forwards.
  assign exmem_hit_c = iExmem_we && (iExmem_rd != '0) && (iExmem_rd == iRs);
  assign memwb_hit_c = iMemwb_we && (iMemwb_rd != '0) && (iMemwb_rd == iRs);

  // The younger EX/MEM result wins a double match.
  always_comb begin
    oSel = FWD_REG;
    if (iValid && iUse) begin
      if (exmem_hit_c) begin
        oSel = FWD_EXMEM;
      end else if (memwb_hit_c) begin
        oSel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with WB bypass, load-use bubble, flush and hold.
//   iClk, iReset_n            clock, async active-low reset
//   iValid_id .. iCtrl        ID-stage instruction fields and regfile read data
//   iWb_we/waddr/wdata        WB write port (bypassed into captured operands)
//   iExmem_*, iMemwb_*        downstream producers for EX forwarding
//   iFlush, iHold             kill ID instruction / freeze stage
//   oStall                    combinational: hold PC and IF/ID
//   oValid_ex .. oCtrl        registered EX-stage fields
//   oFwdA, oFwdB              combinational EX forwarding selects
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
) (
  input  logic            iClk,
  input  logic            iReset_n,
  input  logic            iValid_id,
  input  logic [XLEN-1:0] iPc,
  input  logic [REGW-1:0] iRs1,
  input  logic [REGW-1:0] iRs2,
  input  logic [REGW-1:0] iRd,
  input  logic [XLEN-1:0] iRdata1,
  input  logic [XLEN-1:0] iRdata2,
  input  logic [XLEN-1:0] iImm,
  input  ctrl_t           iCtrl,
  input  logic            iWb_we,
  input  logic [REGW-1:0] iWb_waddr,
  input  logic [XLEN-1:0] iWb_wdata,
  input  logic            iExmem_we,
  input  logic [REGW-1:0] iExmem_rd,
  input  logic            iMemwb_we,
  input  logic [REGW-1:0] iMemwb_rd,
  input  logic            iFlush,
  input  logic            iHold,
  output logic            oStall,
  output logic            oValid_ex,
  output logic [XLEN-1:0] oPc,
  output logic [XLEN-1:0] oImm,
  output logic [REGW-1:0] oRs1,
  output logic [REGW-1:0] oRs2,
  output logic [REGW-1:0] oRd,
  output logic [XLEN-1:0] oOp1,
  output logic [XLEN-1:0] oOp2,
  output ctrl_t           oCtrl,
  output fwd_sel_t        oFwdA,
  output fwd_sel_t        oFwdB
);

  logic            lu_c;
  logic            byp1_c;
  logic            byp2_c;
  logic [XLEN-1:0] op1_nxt_c;
  logic [XLEN-1:0] op2_nxt_c;

  // Load in EX whose destination is read by the ID instruction.
  assign lu_c = oValid_ex && oCtrl.memread && (oRd != '0) && iValid_id &&
                (((oRd == iRs1) && iCtrl.use_rs1) ||
                 ((oRd == iRs2) && iCtrl.use_rs2));

  assign oStall = iHold || (lu_c && !iFlush);

  // Regfile write lands only at the edge, so same-cycle WB data is taken directly.
  assign byp1_c    = iWb_we && (iWb_waddr != '0) && (iWb_waddr == iRs1);
  assign byp2_c    = iWb_we && (iWb_waddr != '0) && (iWb_waddr == iRs2);
  assign op1_nxt_c = byp1_c ? iWb_wdata : iRdata1;
  assign op2_nxt_c = byp2_c ? iWb_wdata : iRdata2;

  // Stage register: hold > flush > load-use bubble > capture.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      oValid_ex <= 1'b0;
      oPc       <= '0;
      oImm      <= '0;
      oRs1      <= '0;
      oRs2      <= '0;
      oRd       <= '0;
      oOp1      <= '0;
      oOp2      <= '0;
      oCtrl     <= '0;
    end else if (iHold) begin
      oValid_ex <= oValid_ex;
    end else if (iFlush || lu_c) begin
      oValid_ex <= 1'b0;
      oPc       <= '0;
      oImm      <= '0;
      oRs1      <= '0;
      oRs2      <= '0;
      oRd       <= '0;
      oOp1      <= '0;
      oOp2      <= '0;
      oCtrl     <= '0;
    end else begin
      oValid_ex <= iValid_id;
      oPc       <= iPc;
      oImm      <= iImm;
      oRs1      <= iRs1;
      oRs2      <= iRs2;
      oRd       <= iRd;
      oOp1      <= op1_nxt_c;
      oOp2      <= op2_nxt_c;
      oCtrl     <= iValid_id ? iCtrl : '0;
    end
  end

  fwd_unit #(.REGW(REGW)) u_fwd_a (
    .iValid    (oValid_ex),
    .iUse      (oCtrl.use_rs1),
    .iRs       (oRs1),
    .iExmem_we (iExmem_we),
    .iExmem_rd (iExmem_rd),
    .iMemwb_we (iMemwb_we),
    .iMemwb_rd (iMemwb_rd),
    .oSel      (oFwdA)
  );

  fwd_unit #(.REGW(REGW)) u_fwd_b (
    .iValid    (oValid_ex),
    .iUse      (oCtrl.use_rs2),
    .iRs       (oRs2),
    .iExmem_we (iExmem_we),
    .iExmem_rd (iExmem_rd),
    .iMemwb_we (iMemwb_we),
    .iMemwb_rd (iMemwb_rd),
    .oSel      (oFwdB)
  );

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized + directed bench for id_ex_stage against a cycle-level reference model.
module tb_id_ex_stage;
  import pipe_pkg::*;

  logic        iClk, iReset_n;
  logic        iValid_id;
  logic [31:0] iPc, iRdata1, iRdata2, iImm, iWb_wdata;
  logic [4:0]  iRs1, iRs2, iRd, iWb_waddr, iExmem_rd, iMemwb_rd;
  ctrl_t       iCtrl;
  logic        iWb_we, iExmem_we, iMemwb_we, iFlush, iHold;
  logic        oStall, oValid_ex;
  logic [31:0] oPc, oImm, oOp1, oOp2;
  logic [4:0]  oRs1, oRs2, oRd;
  ctrl_t       oCtrl;
  fwd_sel_t    oFwdA, oFwdB;

  id_ex_stage #(.XLEN(32), .REGW(5)) dut (
    .iClk(iClk), .iReset_n(iReset_n), .iValid_id(iValid_id), .iPc(iPc),
    .iRs1(iRs1), .iRs2(iRs2), .iRd(iRd), .iRdata1(iRdata1), .iRdata2(iRdata2),
    .iImm(iImm), .iCtrl(iCtrl), .iWb_we(iWb_we), .iWb_waddr(iWb_waddr),
    .iWb_wdata(iWb_wdata), .iExmem_we(iExmem_we), .iExmem_rd(iExmem_rd),
    .iMemwb_we(iMemwb_we), .iMemwb_rd(iMemwb_rd), .iFlush(iFlush), .iHold(iHold),
    .oStall(oStall), .oValid_ex(oValid_ex), .oPc(oPc), .oImm(oImm),
    .oRs1(oRs1), .oRs2(oRs2), .oRd(oRd), .oOp1(oOp1), .oOp2(oOp2),
    .oCtrl(oCtrl), .oFwdA(oFwdA), .oFwdB(oFwdB)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Reference view of the EX slot.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, imm, op1, op2;
    logic [4:0]  rs1, rs2, rd;
    ctrl_t       ctrl;
  } ex_t;

  ex_t m;
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // Does the instruction now in ID read the result of a load sitting in EX?
  function automatic logic model_lu();
    logic reads;
    reads = (iCtrl.use_rs1 && iRs1 == m.rd) || (iCtrl.use_rs2 && iRs2 == m.rd);
    return m.valid && m.ctrl.memread && m.rd != 0 && iValid_id && reads;
  endfunction

  // Which producer supplies register r to the EX instruction.
  function automatic fwd_sel_t model_fwd(input logic used, input logic [4:0] r);
    if (!m.valid || !used || r == 0) return FWD_REG;
    if (iExmem_we && iExmem_rd == r) return FWD_EXMEM;
    if (iMemwb_we && iMemwb_rd == r) return FWD_MEMWB;
    return FWD_REG;
  endfunction

  // Value the register file effectively holds for r at this edge.
  function automatic logic [31:0] rf_val(input logic [4:0] r, input logic [31:0] rd_data);
    if (iWb_we && r != 0 && iWb_waddr == r) return iWb_wdata;
    return rd_data;
  endfunction

  task automatic chk_regs(input string p);
    chk({p, "_valid"}, 64'(oValid_ex), 64'(m.valid));
    chk({p, "_pc"},    64'(oPc),  64'(m.pc));
    chk({p, "_imm"},   64'(oImm), 64'(m.imm));
    chk({p, "_rs1"},   64'(oRs1), 64'(m.rs1));
    chk({p, "_rs2"},   64'(oRs2), 64'(m.rs2));
    chk({p, "_rd"},    64'(oRd),  64'(m.rd));
    chk({p, "_op1"},   64'(oOp1), 64'(m.op1));
    chk({p, "_op2"},   64'(oOp2), 64'(m.op2));
    chk({p, "_ctrl"},  64'(oCtrl), 64'(m.ctrl));
  endtask

  // One clock with inputs already applied: check comb outputs, advance model, check regs.
  task automatic step(input string p);
    logic lu;
    ex_t  nx;
    @(negedge iClk);
    lu = model_lu();
    chk({p, "_stall"}, 64'(oStall), 64'(iHold || (lu && !iFlush)));
    chk({p, "_fwdA"}, 64'(oFwdA), 64'(model_fwd(m.ctrl.use_rs1, m.rs1)));
    chk({p, "_fwdB"}, 64'(oFwdB), 64'(model_fwd(m.ctrl.use_rs2, m.rs2)));
    nx = m;
    if (!iHold) begin
      if (iFlush || lu) begin
        nx = '0;
      end else begin
        nx.valid = iValid_id;
        nx.pc    = iPc;
        nx.imm   = iImm;
        nx.rs1   = iRs1;
        nx.rs2   = iRs2;
        nx.rd    = iRd;
        nx.op1   = rf_val(iRs1, iRdata1);
        nx.op2   = rf_val(iRs2, iRdata2);
        nx.ctrl  = iValid_id ? iCtrl : '0;
      end
    end
    @(posedge iClk);
    m = nx;
    #1;
    chk_regs(p);
  endtask

  task automatic clear_inputs();
    iValid_id = 0; iPc = 0; iRs1 = 0; iRs2 = 0; iRd = 0;
    iRdata1 = 0; iRdata2 = 0; iImm = 0; iCtrl = '0;
    iWb_we = 0; iWb_waddr = 0; iWb_wdata = 0;
    iExmem_we = 0; iExmem_rd = 0; iMemwb_we = 0; iMemwb_rd = 0;
    iFlush = 0; iHold = 0;
  endtask

  task automatic rand_inputs();
    iValid_id = ($urandom_range(0, 3) != 0);
    iPc       = $urandom;
    iRs1      = 5'($urandom_range(0, 7));
    iRs2      = 5'($urandom_range(0, 7));
    iRd       = 5'($urandom_range(0, 7));
    iRdata1   = $urandom;
    iRdata2   = $urandom;
    iImm      = $urandom;
    iCtrl     = ctrl_t'(12'($urandom));
    iCtrl.memread = ($urandom_range(0, 1) == 0);
    iWb_we    = $urandom_range(0, 1) != 0;
    iWb_waddr = 5'($urandom_range(0, 7));
    iWb_wdata = $urandom;
    iExmem_we = $urandom_range(0, 1) != 0;
    iExmem_rd = 5'($urandom_range(0, 7));
    iMemwb_we = $urandom_range(0, 1) != 0;
    iMemwb_rd = 5'($urandom_range(0, 7));
    iFlush    = ($urandom_range(0, 9) == 0);
    iHold     = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    ctrl_t c;
    m = '0;
    clear_inputs();
    iReset_n = 0;
    repeat (2) @(posedge iClk);
    #1;
    chk_regs("rst");
    chk("rst_fwdA", 64'(oFwdA), 64'(FWD_REG));
    @(negedge iClk);
    iReset_n = 1;
    @(posedge iClk); #1;

    // WB bypass on rs1, then the same with x0 as the write target.
    clear_inputs();
    iValid_id = 1; iRs1 = 5; iRdata1 = 32'h11; iWb_we = 1; iWb_waddr = 5; iWb_wdata = 32'hAB;
    step("byp");
    chk("byp_op1", 64'(oOp1), 64'h0AB);
    iWb_waddr = 0;
    step("byp_x0");
    chk("byp_x0_op1", 64'(oOp1), 64'h011);

    // Load-use: lw x7 in EX, add reading x7 in ID.
    clear_inputs();
    c = '0; c.memread = 1; c.regwrite = 1; c.memtoreg = 1; c.use_rs1 = 1;
    iValid_id = 1; iRd = 7; iRs1 = 2; iCtrl = c; iPc = 32'h100;
    step("lw");
    c = '0; c.regwrite = 1; c.use_rs1 = 1; c.use_rs2 = 1;
    iRs1 = 7; iRs2 = 3; iRd = 9; iCtrl = c; iPc = 32'h104; iRdata1 = 32'h77;
    #1 chk("lu_stall", 64'(oStall), 64'h1);
    step("lu");
    chk("lu_bubble_valid", 64'(oValid_ex), 64'h0);
    chk("lu_bubble_ctrl", 64'(oCtrl), 64'h0);
    #1 chk("lu_release", 64'(oStall), 64'h0);
    step("lu_cap");
    chk("lu_cap_pc", 64'(oPc), 64'h104);

    // Flush beats load-use.
    c = '0; c.memread = 1; c.use_rs1 = 1;
    iRs1 = 1; iRd = 7; iCtrl = c; iPc = 32'h200;
    step("lw2");
    c = '0; c.use_rs1 = 1;
    iRs1 = 7; iRd = 4; iCtrl = c; iFlush = 1;
    #1 chk("flush_lu_stall", 64'(oStall), 64'h0);
    step("flush");
    chk("flush_valid", 64'(oValid_ex), 64'h0);
    iFlush = 0;

    // Forwarding priority on operand A while the EX slot is frozen.
    clear_inputs();
    c = '0; c.use_rs1 = 1;
    iValid_id = 1; iRs1 = 3; iRd = 6; iCtrl = c;
    step("fwd_cap");
    iHold = 1; iExmem_we = 1; iExmem_rd = 3; iMemwb_we = 1; iMemwb_rd = 3;
    #1 chk("fwd_exmem", 64'(oFwdA), 64'(FWD_EXMEM));
    iExmem_we = 0;
    #1 chk("fwd_memwb", 64'(oFwdA), 64'(FWD_MEMWB));
    step("fwd_hold");
    iHold = 0; iRs1 = 0; iMemwb_rd = 0; iExmem_rd = 0; iExmem_we = 1;
    step("fwd_x0");
    #1 chk("fwd_x0_reg", 64'(oFwdA), 64'(FWD_REG));

    // Hold for three cycles with changing ID inputs.
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      iHold = 1;
      step("hold");
    end

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      step("rnd");
    end

    // Asynchronous reset mid-cycle after loading a valid instruction.
    clear_inputs();
    iValid_id = 1; iPc = 32'h300; iRd = 5; iCtrl = ctrl_t'(12'hFFF);
    step("pre_rst");
    #2 iReset_n = 0;
    #1;
    m = '0;
    chk_regs("arst");
    #1 iReset_n = 1;
    rand_inputs();
    iHold = 0;
    step("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
